// File: rtl/wb_tube_dma.sv
// ==========================================================================
// wb_tube_dma : single-channel byte DMA (Wishbone slave config, master mover)
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_tube_dma (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [2:0]  wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    input  logic [1:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic [18:0] wbm_adr_o,
    output logic        wbm_tga_o,
    output logic [1:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        drq,
    output logic        dma_irq
);

    localparam logic [2:0] c_SRCLO = 3'd0;
    localparam logic [2:0] c_SRCHI = 3'd1;
    localparam logic [2:0] c_DSTLO = 3'd2;
    localparam logic [2:0] c_DSTHI = 3'd3;
    localparam logic [2:0] c_TC    = 3'd4;
    localparam logic [2:0] c_CTRL  = 3'd5;

    localparam int c_ST      = 0;
    localparam int c_SRC_IO  = 1;
    localparam int c_DST_IO  = 2;
    localparam int c_SRC_INC = 3;
    localparam int c_DST_INC = 4;
    localparam int c_SYNC    = 5;
    localparam int c_TC_STOP = 6;
    localparam int c_IRQ_EN  = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAITDRQ = 3'd1,
        S_RD      = 3'd2,
        S_GAP1    = 3'd3,
        S_WR      = 3'd4,
        S_GAP2    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [19:0] r_src;
    logic [19:0] r_dst;
    logic [15:0] r_tc;
    logic [7:0]  r_ctrl;
    logic        r_irq;
    logic        r_ack;
    logic [15:0] r_rdat;
    logic [1:0]  r_drq_sync;
    logic [1:0]  r_gap_cnt;
    logic [7:0]  r_byte;

    logic [18:0] r_madr;
    logic        r_mtga;
    logic [1:0]  r_msel;
    logic        r_mwe;
    logic        r_mcyc;
    logic [15:0] r_mdat;

    logic        w_busy;
    logic        w_acc;
    logic        w_wr_acc;
    logic        w_ctrl_wr;
    logic        w_rd_done;
    logic        w_wr_done;
    logic        w_tc_zero;
    logic [15:0] w_rdat;
    logic [18:0] w_src_adr;
    logic [18:0] w_dst_adr;
    logic [1:0]  w_src_sel;
    logic [1:0]  w_dst_sel;

    assign w_busy    = (r_state != S_IDLE);
    assign w_acc     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr_acc  = w_acc & wbs_we_i;
    assign w_ctrl_wr = w_wr_acc & (wbs_adr_i == c_CTRL);
    assign w_rd_done = (r_state == S_RD) & r_mcyc & wbm_ack_i;
    assign w_wr_done = (r_state == S_WR) & r_mcyc & wbm_ack_i;
    assign w_tc_zero = (r_tc == 16'h0000);

    // I/O pointers live in a 16-bit space: upper address bits forced to zero.
    assign w_src_adr = r_ctrl[c_SRC_IO] ? {4'h0, r_src[15:1]} : r_src[19:1];
    assign w_dst_adr = r_ctrl[c_DST_IO] ? {4'h0, r_dst[15:1]} : r_dst[19:1];
    assign w_src_sel = r_src[0] ? 2'b10 : 2'b01;
    assign w_dst_sel = r_dst[0] ? 2'b10 : 2'b01;

    always_comb begin
        w_rdat = 16'h0000;
        case (wbs_adr_i)
            c_SRCLO: w_rdat = r_src[15:0];
            c_SRCHI: w_rdat = {12'h000, r_src[19:16]};
            c_DSTLO: w_rdat = r_dst[15:0];
            c_DSTHI: w_rdat = {12'h000, r_dst[19:16]};
            c_TC:    w_rdat = r_tc;
            c_CTRL:  w_rdat = {7'h00, w_busy, r_ctrl};
            default: w_rdat = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[c_ST]) begin
                    if (r_ctrl[c_TC_STOP] && w_tc_zero) w_state_nxt = S_DONE;
                    else if (r_ctrl[c_SYNC])            w_state_nxt = S_WAITDRQ;
                    else                                w_state_nxt = S_RD;
                end
            end
            S_WAITDRQ: begin
                if (r_drq_sync[1])     w_state_nxt = S_RD;
                else if (!r_ctrl[c_ST]) w_state_nxt = S_IDLE;
            end
            S_RD:   if (w_rd_done) w_state_nxt = S_GAP1;
            S_GAP1: w_state_nxt = S_WR;
            S_WR:   if (w_wr_done) w_state_nxt = S_GAP2;
            S_GAP2: begin
                // In SYNC mode linger so the old drq level drains out of the synchroniser.
                if (r_ctrl[c_TC_STOP] && w_tc_zero) w_state_nxt = S_DONE;
                else if (!r_ctrl[c_ST])             w_state_nxt = S_IDLE;
                else if (!r_ctrl[c_SYNC])           w_state_nxt = S_RD;
                else if (r_gap_cnt == 2'd2)         w_state_nxt = S_WAITDRQ;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_gap_cnt  <= 2'd0;
            r_drq_sync <= 2'b00;
            r_byte     <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_drq_sync <= {r_drq_sync[0], drq};
            if (r_state == S_GAP2 && w_state_nxt == S_GAP2) r_gap_cnt <= r_gap_cnt + 2'd1;
            else                                            r_gap_cnt <= 2'd0;
            if (w_rd_done) r_byte <= r_src[0] ? wbm_dat_i[15:8] : wbm_dat_i[7:0];
        end
    end

    // Bus fields load on entry to RD/WR and stay frozen until the ack.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_mcyc <= 1'b0;
            r_madr <= 19'h00000;
            r_mtga <= 1'b0;
            r_msel <= 2'b00;
            r_mwe  <= 1'b0;
            r_mdat <= 16'h0000;
        end else if (w_state_nxt == S_RD) begin
            r_mcyc <= 1'b1;
            if (r_state != S_RD) begin
                r_madr <= w_src_adr;
                r_mtga <= r_ctrl[c_SRC_IO];
                r_msel <= w_src_sel;
                r_mwe  <= 1'b0;
                r_mdat <= 16'h0000;
            end
        end else if (w_state_nxt == S_WR) begin
            r_mcyc <= 1'b1;
            if (r_state != S_WR) begin
                r_madr <= w_dst_adr;
                r_mtga <= r_ctrl[c_DST_IO];
                r_msel <= w_dst_sel;
                r_mwe  <= 1'b1;
                r_mdat <= {r_byte, r_byte};
            end
        end else begin
            r_mcyc <= 1'b0;
            r_madr <= 19'h00000;
            r_mtga <= 1'b0;
            r_msel <= 2'b00;
            r_mwe  <= 1'b0;
            r_mdat <= 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_ack  <= 1'b0;
            r_rdat <= 16'h0000;
            r_src  <= 20'h00000;
            r_dst  <= 20'h00000;
            r_tc   <= 16'h0000;
            r_ctrl <= 8'h00;
            r_irq  <= 1'b0;
        end else begin
            r_ack  <= w_acc;
            r_rdat <= w_acc ? w_rdat : 16'h0000;

            if (w_wr_acc && !w_busy) begin
                case (wbs_adr_i)
                    c_SRCLO: begin
                        if (wbs_sel_i[0]) r_src[7:0]  <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) r_src[15:8] <= wbs_dat_i[15:8];
                    end
                    c_SRCHI: if (wbs_sel_i[0]) r_src[19:16] <= wbs_dat_i[3:0];
                    c_DSTLO: begin
                        if (wbs_sel_i[0]) r_dst[7:0]  <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) r_dst[15:8] <= wbs_dat_i[15:8];
                    end
                    c_DSTHI: if (wbs_sel_i[0]) r_dst[19:16] <= wbs_dat_i[3:0];
                    c_TC: begin
                        if (wbs_sel_i[0]) r_tc[7:0]  <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) r_tc[15:8] <= wbs_dat_i[15:8];
                    end
                    default: ;
                endcase
            end

            if (w_wr_done) begin
                r_tc  <= r_tc - 16'd1;
                r_src <= r_src + {19'h00000, r_ctrl[c_SRC_INC]};
                r_dst <= r_dst + {19'h00000, r_ctrl[c_DST_INC]};
            end

            // A software CTRL write lands after DONE so it wins on ST.
            if (r_state == S_DONE) r_ctrl[c_ST] <= 1'b0;
            if (w_ctrl_wr && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[7:0];

            if (w_ctrl_wr) r_irq <= 1'b0;
            if (r_state == S_DONE && r_ctrl[c_IRQ_EN]) r_irq <= 1'b1;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdat;
    assign wbm_adr_o = r_madr;
    assign wbm_tga_o = r_mtga;
    assign wbm_sel_o = r_msel;
    assign wbm_we_o  = r_mwe;
    assign wbm_cyc_o = r_mcyc;
    assign wbm_stb_o = r_mcyc;
    assign wbm_dat_o = r_mdat;
    assign dma_irq   = r_irq;

endmodule

`default_nettype wire
